pdu_serial_frontend: RTL and testbench

- Bit-serial operand/result stage wrapped around the 20-bit combinational divider.
- Deserialises dividend then divisor (LSB first, word-mark framed) from the serial data bus and presents both words in parallel to the divider.
- Waits a fixed settle time, captures quotient/remainder and re-serialises them onto the output bus.
- Sits directly upstream (operand feed) and downstream (result capture) of the divider in the arithmetic path.

---
 rtl/pdu_serial_frontend_pkg.sv | 21 ++
 rtl/pdu_ser2par.sv | 26 ++
 rtl/pdu_serial_frontend.sv | 186 ++++++++++++++++++
 tb/tb_pdu_serial_frontend.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pdu_serial_frontend_pkg.sv
// Shared types and constants for the divider serial front end.
// Output frame length follows PDU_REMAINDER_OUT_EN.
package pdu_serial_frontend_pkg;

  localparam int PDU_WIDTH = 20;

`ifdef PDU_REMAINDER_OUT_EN
  localparam int FRAME_WORDS = 2;
`else
  localparam int FRAME_WORDS = 1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DVD,
    LOAD_DVS,
    SETTLE,
    SHIFT_OUT
  } state_t;

endpackage

// File: rtl/pdu_ser2par.sv
// LSB-first serial-to-parallel register.
// Bits land at an explicit index so stalls never shift.
module pdu_ser2par
  import pdu_serial_frontend_pkg::*;
#(
  parameter int WIDTH = PDU_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [$clog2(WIDTH)-1:0] idx,
  input  logic                     din,
  output logic [WIDTH-1:0]         q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      if (clr) q <= '0;
      if (wr)  q[idx] <= din;
    end
  end

endmodule

// File: rtl/pdu_serial_frontend.sv
// Bit-serial operand feed and result capture around the divider.
// PDU_REMAINDER_OUT_EN appends the remainder to the output frame.
module pdu_serial_frontend
  import pdu_serial_frontend_pkg::*;
#(
  parameter int WIDTH         = PDU_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             in_valid,
  input  logic             word_mark,
  output logic             busy,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             ser_out,
  output logic             out_valid,
  output logic             out_mark,
  output logic             div_zero
);

  localparam int IW       = $clog2(WIDTH);
  localparam int OUT_BITS = FRAME_WORDS * WIDTH;
  localparam int OW       = $clog2(OUT_BITS + 1);
  localparam int SW       = $clog2(SETTLE_CYCLES + 1);

  state_t              state;
  logic [IW-1:0]       bit_cnt;
  logic [SW-1:0]       settle_cnt;
  logic [OW-1:0]       out_cnt;
  logic [OUT_BITS-1:0] out_sr;
  logic [OUT_BITS-1:0] cap;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvs_full;
  logic [IW-1:0]    wr_idx;
  logic             dvd_clr;
  logic             dvd_wr;
  logic             dvs_clr;
  logic             dvs_wr;
  logic             frame_start;
  logic             last_bit;

  assign frame_start = in_valid && word_mark &&
                       (state inside {IDLE, LOAD_DVD, LOAD_DVS});
  assign last_bit    = (bit_cnt == IW'(WIDTH - 1));

`ifdef PDU_REMAINDER_OUT_EN
  assign cap = {div_remainder, div_quotient};
`else
  logic unused_rem;
  assign unused_rem = ^div_remainder;
  assign cap        = div_quotient;
`endif

  always_comb begin
    dvd_clr = 1'b0;
    dvd_wr  = 1'b0;
    dvs_clr = 1'b0;
    dvs_wr  = 1'b0;
    wr_idx  = bit_cnt;
    unique case (1'b1)
      frame_start: begin
        dvd_clr = 1'b1;
        dvd_wr  = 1'b1;
        dvs_clr = 1'b1;
        wr_idx  = '0;
      end
      in_valid && !word_mark && state == LOAD_DVD:
        dvd_wr = 1'b1;
      in_valid && !word_mark && state == LOAD_DVS:
        dvs_wr = 1'b1;
      default: ;
    endcase
  end

  // Divisor as it will be once the bit on ser_in is stored.
  always_comb begin
    dvs_full            = dvs_q;
    dvs_full[WIDTH-1]   = ser_in;
  end

  pdu_ser2par #(.WIDTH(WIDTH)) u_dvd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dvd_clr),
    .wr    (dvd_wr),
    .idx   (wr_idx),
    .din   (ser_in),
    .q     (dvd_q)
  );

  pdu_ser2par #(.WIDTH(WIDTH)) u_dvs (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dvs_clr),
    .wr    (dvs_wr),
    .idx   (wr_idx),
    .din   (ser_in),
    .q     (dvs_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      settle_cnt   <= '0;
      out_cnt      <= '0;
      out_sr       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      ser_out      <= 1'b0;
      out_valid    <= 1'b0;
      out_mark     <= 1'b0;
      busy         <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      out_mark <= 1'b0;
      div_zero <= 1'b0;
      if (frame_start) begin
        state   <= LOAD_DVD;
        bit_cnt <= IW'(1);
        busy    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          LOAD_DVD: begin
            if (in_valid) begin
              if (last_bit) begin
                bit_cnt <= '0;
                state   <= LOAD_DVS;
              end else begin
                bit_cnt <= bit_cnt + IW'(1);
              end
            end
          end
          LOAD_DVS: begin
            if (in_valid) begin
              if (last_bit) begin
                bit_cnt      <= '0;
                div_dividend <= dvd_q;
                div_divisor  <= dvs_full;
                settle_cnt   <= SW'(SETTLE_CYCLES);
                state        <= SETTLE;
              end else begin
                bit_cnt <= bit_cnt + IW'(1);
              end
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              out_sr    <= cap >> 1;
              ser_out   <= cap[0];
              out_valid <= 1'b1;
              out_mark  <= 1'b1;
              div_zero  <= (div_divisor == '0);
              out_cnt   <= OW'(1);
              state     <= SHIFT_OUT;
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
          SHIFT_OUT: begin
            if (out_cnt == OW'(OUT_BITS)) begin
              ser_out   <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_cnt   <= '0;
              state     <= IDLE;
            end else begin
              ser_out <= out_sr[0];
              out_sr  <= out_sr >> 1;
              out_cnt <= out_cnt + OW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pdu_serial_frontend.sv
// Directed bench for pdu_serial_frontend with a constant stub divider.
// Define PDU_REMAINDER_OUT_EN to check the two-word output frame.
module tb_pdu_serial_frontend;

  localparam int W      = 20;
  localparam int SETTLE = 2;
`ifdef PDU_REMAINDER_OUT_EN
  localparam int OUT_BITS = 2 * W;
`else
  localparam int OUT_BITS = W;
`endif

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic ser_in    = 1'b0;
  logic in_valid  = 1'b0;
  logic word_mark = 1'b0;
  logic busy;
  logic ser_out;
  logic out_valid;
  logic out_mark;
  logic div_zero;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign div_quotient  = 20'h00ABC;
  assign div_remainder = 20'h00005;

  pdu_serial_frontend #(
    .WIDTH         (W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ser_in        (ser_in),
    .in_valid      (in_valid),
    .word_mark     (word_mark),
    .busy          (busy),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .ser_out       (ser_out),
    .out_valid     (out_valid),
    .out_mark      (out_mark),
    .div_zero      (div_zero)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_stream();
    logic [63:0] s;
`ifdef PDU_REMAINDER_OUT_EN
    s = {24'h0, 20'h00005, 20'h00ABC};
`else
    s = {44'h0, 20'h00ABC};
`endif
    return s;
  endfunction

  task automatic send_frame(input logic [W-1:0] dvd,
                            input logic [W-1:0] dvs,
                            input bit gap);
    logic [2*W-1:0] bits;
    bits = {dvs, dvd};
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      ser_in    = bits[i];
      word_mark = (i == 0);
      if (gap && i < 2 * W - 1) begin
        @(negedge clk);
        in_valid  = 1'b0;
        word_mark = 1'b0;
        ser_in    = ~ser_in;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    word_mark = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic run_frame(input string tag,
                           input logic [W-1:0] dvd,
                           input logic [W-1:0] dvs,
                           input bit gap,
                           input int exp_zero);
    logic [63:0] stream;
    int nb, lat, zc, zat, merr, berr;
    bit done;
    stream = '0;
    nb = 0; lat = -1; zc = 0; zat = -1;
    merr = 0; berr = 0; done = 1'b0;
    send_frame(dvd, dvs, gap);
    chk($sformatf("%s dividend", tag), 64'(div_dividend), 64'(dvd));
    chk($sformatf("%s divisor", tag), 64'(div_divisor), 64'(dvs));
    for (int k = 0; k < 300 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (div_zero) begin
        zc++;
        zat = k;
      end
      if (out_valid) begin
        if (nb == 0) lat = k;
        if (out_mark != (nb == 0)) merr++;
        if (!busy) berr++;
        if (nb < 64) stream[nb] = ser_out;
        nb++;
      end else if (nb > 0) begin
        done = 1'b1;
        chk($sformatf("%s busy after", tag), 64'(busy), 64'(0));
      end
    end
    chk($sformatf("%s complete", tag), 64'(done), 64'(1));
    chk($sformatf("%s latency", tag), 64'(lat), 64'(SETTLE + 1));
    chk($sformatf("%s bit count", tag), 64'(nb), 64'(OUT_BITS));
    chk($sformatf("%s stream", tag), stream, exp_stream());
    chk($sformatf("%s mark errs", tag), 64'(merr), 64'(0));
    chk($sformatf("%s busy errs", tag), 64'(berr), 64'(0));
    chk($sformatf("%s zero pulses", tag), 64'(zc), 64'(exp_zero));
    chk($sformatf("%s zero cycle", tag), 64'(zat),
        64'((exp_zero != 0) ? lat : -1));
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst ser_out", 64'(ser_out), 64'(0));
    chk("rst out_mark", 64'(out_mark), 64'(0));
    chk("rst div_zero", 64'(div_zero), 64'(0));
    chk("rst dividend", 64'(div_dividend), 64'(0));
    chk("rst divisor", 64'(div_divisor), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("basic", 20'h12345, 20'h00019, 1'b0, 0);
    run_frame("stall", 20'h12345, 20'h00019, 1'b1, 0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      ser_in    = 1'b1;
      word_mark = (i == 0);
    end
    run_frame("resync", 20'h0F0F0, 20'h00007, 1'b0, 0);

    run_frame("divzero", 20'h12345, 20'h00000, 1'b0, 1);

    send_frame(20'h12345, 20'h00019, 1'b0);
    bad = 1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        bad = 0;
        break;
      end
      @(negedge clk);
    end
    chk("midrst reached output", 64'(bad), 64'(0));
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst flags",
        64'({busy, out_valid, ser_out, out_mark, div_zero}), 64'(0));
    chk("midrst dividend", 64'(div_dividend), 64'(0));
    chk("midrst divisor", 64'(div_divisor), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      word_mark = 1'b0;
      ser_in    = k[0];
      if (busy || out_valid) bad++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (busy || out_valid) bad++;
    chk("idle ignores unmarked", 64'(bad), 64'(0));
    run_frame("post", 20'h00F00, 20'h00030, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
